// File: rtl/write_fsm.sv
// Single-transaction DDR write sequencer: ACT, tRCD, WR, CWL, BL data beats, tWR, PRE, tRP, done.
// Closed-page: every accepted request opens and closes its own row.
module write_fsm #(
    parameter int unsigned BA_W  = 3,
    parameter int unsigned ROW_W = 14,
    parameter int unsigned COL_W = 10,
    parameter int unsigned DQ_W  = 16,
    parameter int unsigned BL    = 8,
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_CWL = 2,
    parameter int unsigned T_WR  = 4,
    parameter int unsigned T_RP  = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_req,
    input  logic [BA_W-1:0]  wr_bank,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    output logic             wr_ready,
    input  logic [DQ_W-1:0]  wr_data,
    output logic             wr_pop,
    output logic [1:0]       cmd,
    output logic [BA_W-1:0]  cmd_bank,
    output logic [ROW_W-1:0] cmd_addr,
    output logic [DQ_W-1:0]  dq_out,
    output logic             dq_oe,
    output logic             busy,
    output logic             done
);

    localparam int unsigned T_MAX_A = (T_RCD > T_CWL) ? T_RCD : T_CWL;
    localparam int unsigned T_MAX_B = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = $clog2(T_MAX + BL + 1);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_WR, S_WAIT_CWL,
        S_DATA, S_WAIT_WR, S_PRE, S_WAIT_RP, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BA_W-1:0]    r_bank, w_bank_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic [COL_W-1:0]   r_col, w_col_nxt;
    logic               w_accept;

    logic [1:0]         r_cmd, w_cmd;
    logic [ROW_W-1:0]   r_cmd_addr, w_cmd_addr;
    logic               r_dq_oe, w_dq_oe;
    logic               r_done, w_done;
    logic               r_wr_ready, w_wr_ready;

    assign w_accept   = (r_state == S_IDLE) && wr_req;
    assign w_bank_nxt = w_accept ? wr_bank : r_bank;
    assign w_row_nxt  = w_accept ? wr_row  : r_row;
    assign w_col_nxt  = w_accept ? wr_col  : r_col;

    // Every wait loads the shared counter with (duration-1) on entry and exits at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: if (wr_req) w_state_nxt = S_ACT;
            S_ACT: begin
                if (T_RCD > 1) begin
                    w_state_nxt = S_WAIT_RCD;
                    w_cnt_nxt   = CNT_W'(T_RCD - 2);
                end else begin
                    w_state_nxt = S_WR;
                end
            end
            S_WAIT_RCD: begin
                if (r_cnt == '0) w_state_nxt = S_WR;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_WR: begin
                if (T_CWL > 1) begin
                    w_state_nxt = S_WAIT_CWL;
                    w_cnt_nxt   = CNT_W'(T_CWL - 2);
                end else begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = CNT_W'(BL - 1);
                end
            end
            S_WAIT_CWL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = CNT_W'(BL - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (T_WR > 0) begin
                    w_state_nxt = S_WAIT_WR;
                    w_cnt_nxt   = CNT_W'(T_WR - 1);
                end else begin
                    w_state_nxt = S_PRE;
                end
            end
            S_WAIT_WR: begin
                if (r_cnt == '0) w_state_nxt = S_PRE;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    w_state_nxt = S_WAIT_RP;
                    w_cnt_nxt   = CNT_W'(T_RP - 2);
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT_RP: begin
                if (r_cnt == '0) w_state_nxt = S_DONE;
                else             w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        w_cmd      = CMD_NOP;
        w_cmd_addr = '0;
        w_dq_oe    = 1'b0;
        w_done     = 1'b0;
        w_wr_ready = 1'b0;
        case (w_state_nxt)
            S_IDLE: w_wr_ready = 1'b1;
            S_ACT: begin
                w_cmd      = CMD_ACT;
                w_cmd_addr = w_row_nxt;
            end
            S_WR: begin
                w_cmd      = CMD_WR;
                w_cmd_addr = ROW_W'(w_col_nxt);
            end
            S_DATA:  w_dq_oe = 1'b1;
            S_PRE:   w_cmd   = CMD_PRE;
            S_DONE:  w_done  = 1'b1;
            default: w_cmd   = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bank     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_cmd      <= CMD_NOP;
            r_cmd_addr <= '0;
            r_dq_oe    <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bank     <= w_bank_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_cmd      <= w_cmd;
            r_cmd_addr <= w_cmd_addr;
            r_dq_oe    <= w_dq_oe;
            r_done     <= w_done;
            r_wr_ready <= w_wr_ready;
        end
    end

    assign wr_ready = r_wr_ready;
    assign busy     = ~r_wr_ready;
    assign cmd      = r_cmd;
    assign cmd_bank = r_bank;
    assign cmd_addr = r_cmd_addr;
    assign dq_oe    = r_dq_oe;
    assign wr_pop   = r_dq_oe;
    assign done     = r_done;
    // Show-ahead FIFO head is passed straight through during the burst.
    assign dq_out   = r_dq_oe ? wr_data : '0;

endmodule

// File: tb/tb_write_fsm.sv
// Scoreboard bench for write_fsm: default-timing instance A and minimum-timing instance B.
module tb_write_fsm;

    localparam int unsigned BA_W  = 3;
    localparam int unsigned ROW_W = 14;
    localparam int unsigned COL_W = 10;
    localparam int unsigned DQ_W  = 16;

    localparam int K_ACT  = 1;
    localparam int K_WR   = 2;
    localparam int K_PRE  = 3;
    localparam int K_DATA = 4;
    localparam int K_DONE = 5;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             req_a, req_b;
    logic [BA_W-1:0]  bank_a, bank_b, cbank_a, cbank_b;
    logic [ROW_W-1:0] row_a, row_b, caddr_a, caddr_b;
    logic [COL_W-1:0] col_a, col_b;
    logic [DQ_W-1:0]  data_a, data_b, dqo_a, dqo_b;
    logic             ready_a, ready_b, pop_a, pop_b, oe_a, oe_b;
    logic             busy_a, busy_b, done_a, done_b;
    logic [1:0]       cmd_a, cmd_b;

    int ptr_a = 0;
    int ptr_b = 0;
    always @(posedge clk) begin
        if (pop_a) ptr_a <= ptr_a + 1;
        if (pop_b) ptr_b <= ptr_b + 1;
    end
    assign data_a = 16'hA000 + 16'(ptr_a);
    assign data_b = 16'hB000 + 16'(ptr_b);

    write_fsm u_dut_a (
        .clk(clk), .n_rst(n_rst), .wr_req(req_a), .wr_bank(bank_a), .wr_row(row_a),
        .wr_col(col_a), .wr_ready(ready_a), .wr_data(data_a), .wr_pop(pop_a),
        .cmd(cmd_a), .cmd_bank(cbank_a), .cmd_addr(caddr_a), .dq_out(dqo_a),
        .dq_oe(oe_a), .busy(busy_a), .done(done_a)
    );

    write_fsm #(.BL(1), .T_RCD(1), .T_CWL(1), .T_WR(0), .T_RP(1)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .wr_req(req_b), .wr_bank(bank_b), .wr_row(row_b),
        .wr_col(col_b), .wr_ready(ready_b), .wr_data(data_b), .wr_pop(pop_b),
        .cmd(cmd_b), .cmd_bank(cbank_b), .cmd_addr(caddr_b), .dq_out(dqo_b),
        .dq_oe(oe_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int kind;
        int cyc;
        int val;
        int bank;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   beat_a = 0;
    int   beat_b = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int d, input int kind, input int c, input int val, input int bank);
        exp_t e;
        e.kind = kind; e.cyc = c; e.val = val; e.bank = bank;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    // Default timing: ACT +1, WR +4, data +6..+13, PRE +18, done +21 relative to acceptance.
    task automatic push_a(input int t0, input int bank, input int row, input int col, input int nbeats,
                          input bit full);
        push(0, K_ACT, t0 + 1, row, bank);
        push(0, K_WR,  t0 + 4, col, bank);
        for (int i = 0; i < nbeats; i++) begin
            push(0, K_DATA, t0 + 6 + i, 32'hA000 + beat_a, bank);
            beat_a++;
        end
        if (full) begin
            push(0, K_PRE,  t0 + 18, 0, bank);
            push(0, K_DONE, t0 + 21, 0, bank);
        end
    endtask

    task automatic push_b(input int t0, input int bank, input int row, input int col);
        push(1, K_ACT,  t0 + 1, row, bank);
        push(1, K_WR,   t0 + 2, col, bank);
        push(1, K_DATA, t0 + 3, 32'hB000 + beat_b, bank);
        beat_b++;
        push(1, K_PRE,  t0 + 4, 0, bank);
        push(1, K_DONE, t0 + 5, 0, bank);
    endtask

    task automatic observe(input int d, input int kind, input int val, input int bank);
        exp_t e;
        string nm;
        nm = (d == 0) ? "evt_a" : "evt_b";
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            chk({nm, "_unexpected"}, 64'(kind), 64'(0));
        end else begin
            e = (d == 0) ? qa.pop_front() : qb.pop_front();
            chk(nm, {16'(kind), 16'(cyc), 16'(val), 16'(bank)},
                    {16'(e.kind), 16'(e.cyc), 16'(e.val), 16'(e.bank)});
        end
    endtask

    // Monitor: every command, data beat and done pulse is matched against the queue head.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (cmd_a != 2'b00) observe(0, int'(cmd_a), int'(caddr_a), int'(cbank_a));
            if (oe_a)           observe(0, K_DATA, int'(dqo_a), int'(cbank_a));
            if (!oe_a && (dqo_a != '0 || pop_a)) chk("quiet_dq_a", {dqo_a, 15'(0), pop_a}, 32'(0));
            if (done_a)         observe(0, K_DONE, 0, int'(cbank_a));
            if (cmd_b != 2'b00) observe(1, int'(cmd_b), int'(caddr_b), int'(cbank_b));
            if (oe_b)           observe(1, K_DATA, int'(dqo_b), int'(cbank_b));
            if (done_b)         observe(1, K_DONE, 0, int'(cbank_b));
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    int t0;
    int p0;

    initial begin
        n_rst = 1'b0;
        req_a = 1'b0; bank_a = '0; row_a = '0; col_a = '0;
        req_b = 1'b0; bank_b = '0; row_b = '0; col_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_a", {ready_a, busy_a, cmd_a, oe_a, pop_a, done_a, dqo_a, caddr_a, cbank_a},
                       {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 14'h0, 3'h0});
        chk("reset_b", {ready_b, busy_b, cmd_b, oe_b, done_b}, {1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
        n_rst = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk("idle", {ready_a, cmd_a, oe_a, done_a}, {1'b1, 2'b00, 1'b0, 1'b0});
        end

        // Single transaction; address inputs scrambled right after acceptance.
        t0 = cyc;
        req_a = 1'b1; bank_a = 3'd5; row_a = 14'h1234; col_a = 10'h008;
        push_a(t0, 5, 'h1234, 'h008, 8, 1'b1);
        @(negedge clk);
        req_a = 1'b0; bank_a = 3'd1; row_a = 14'h3FFF; col_a = 10'h3FF;
        wait_until(t0 + 21);
        chk("ready_at_done", {ready_a, busy_a}, {1'b0, 1'b1});
        wait_until(t0 + 22);
        chk("ready_after_done", {ready_a, busy_a}, {1'b1, 1'b0});
        chk("pops_txn1", 64'(ptr_a), 64'(8));

        // Request held high: back-to-back transactions, 22-cycle period.
        t0 = cyc;
        req_a = 1'b1; bank_a = 3'd2; row_a = 14'h3ABC; col_a = 10'h3FF;
        push_a(t0, 2, 'h3ABC, 'h3FF, 8, 1'b1);
        push_a(t0 + 22, 2, 'h3ABC, 'h3FF, 8, 1'b1);
        wait_until(t0 + 10);
        chk("busy_ignores_req", {ready_a, busy_a}, {1'b0, 1'b1});
        wait_until(t0 + 23);
        req_a = 1'b0;
        wait_until(t0 + 44);
        chk("b2b_ready", 64'(ready_a), 64'(1));
        chk("pops_b2b", 64'(ptr_a), 64'(24));

        // Reset during the burst after three beats.
        t0 = cyc;
        p0 = ptr_a;
        req_a = 1'b1; bank_a = 3'd7; row_a = 14'h0055; col_a = 10'h2A0;
        push_a(t0, 7, 'h0055, 'h2A0, 3, 1'b0);
        @(negedge clk);
        req_a = 1'b0;
        wait_until(t0 + 8);
        @(posedge clk);
        #2;
        chk("pre_abort_oe", 64'(oe_a), 64'(1));
        n_rst = 1'b0;
        #1;
        chk("abort_async", {oe_a, pop_a, cmd_a, done_a, ready_a, dqo_a},
                           {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0});
        @(negedge clk);
        n_rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("pops_abort", 64'(ptr_a - p0), 64'(3));
        chk("abort_drained", 64'(qa.size()), 64'(0));

        t0 = cyc;
        req_a = 1'b1; bank_a = 3'd4; row_a = 14'h2222; col_a = 10'h111;
        push_a(t0, 4, 'h2222, 'h111, 8, 1'b1);
        @(negedge clk);
        req_a = 1'b0;
        wait_until(t0 + 22);
        chk("post_abort_ready", 64'(ready_a), 64'(1));

        // Minimum timing instance.
        t0 = cyc;
        req_b = 1'b1; bank_b = 3'd3; row_b = 14'h2001; col_b = 10'h155;
        push_b(t0, 3, 'h2001, 'h155);
        @(negedge clk);
        req_b = 1'b0;
        wait_until(t0 + 5);
        chk("min_busy_at_done", 64'(ready_b), 64'(0));
        wait_until(t0 + 6);
        chk("min_ready", 64'(ready_b), 64'(1));
        chk("min_pops", 64'(ptr_b), 64'(1));

        for (int i = 0; i < 50 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
        chk("drain", 64'(qa.size() + qb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
